midi_merge_arbiter: RTL and testbench
=====================================

Name: midi_merge_arbiter

Overview:
- Merges byte streams from up to PORTS MIDI receivers onto one MIDI transmitter: one output port fed by many inputs under routing.
- Sits between the UART RX byte outputs and one UART TX inside midictrl; one instance per output port.
- Grants are message-atomic: a started message is never interleaved with bytes from another port.
- Restores running status on the merged stream, terminates truncated SysEx, and releases a stalled port after a timeout.

Parameters:
- PORTS, 16, number of input requesters.
- CLOCK, 12_000_000, clk frequency in Hz.
- TIMEOUT_MS, 10, mid-message stall limit; TIMEOUT_CYC = CLOCK/1000*TIMEOUT_MS.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  PORTS  head byte available per port.
- in_data  in  8*PORTS  head byte; port i at [8i+7:8i].
- in_ready  out  PORTS  byte consumed (pop) when valid&ready.
- out_valid  out  1  merged byte valid to TX.
- out_data  out  8  merged byte.
- out_ready  in  1  TX accepts byte.
- grant  out  PORTS  one-hot lock owner; 0 when unlocked.
- act  out  PORTS  1-cycle pulse per byte consumed from port i, for activity LEDs.
- timeout  out  1  1-cycle pulse on stall release.

Behaviour:
- Decided: one clock, clk; rst asynchronous active-high; all state cleared on rst assertion.
- Reset values:
  - out_valid=0, out_data=0, in_ready=0, grant=0, act=0, timeout=0.
  - State=IDLE, rr pointer=0, all per-port running status invalid.
- Output register:
  - Holds out_valid/out_data until out_ready.
  - A new byte may load only when out_valid=0 or out_ready=1 (full throughput, 1 byte/cycle).
  - in_ready is combinational from state plus output-register availability; at most one bit high.
- Lengths (midi_pkg::msg_len):
  - 8x,9x,Ax,Bx,Ex,F2 -> 3.
  - Cx,Dx,F1,F3 -> 2.
  - F4-F7 -> 1.
  - F0 -> SysEx (open length).
  - F8-FF -> realtime (1 byte, never locks).
- IDLE:
  - Round-robin pick among valid ports, starting at pointer+1; pick and consume happen in the same cycle.
  - Realtime byte: forward, no lock.
  - 80-EF: forward, store as that port's running status, remaining=len-1, lock -> PASS.
  - F0: forward, clear running status, lock -> SYSEX.
  - F1-F7 other: forward, clear running status, lock for remaining if >0.
  - Data byte with valid running status: do not consume; lock, load status -> INSERT.
  - Data byte with no running status: consume, drop (act still pulses).
  - Pointer <= picked port.
- INSERT: emit stored status byte, remaining=len-1 -> PASS. Consumes no input.
- PASS (locked port only):
  - Data byte: forward, remaining--; at 0 -> IDLE, grant=0.
  - Realtime byte: forward, remaining unchanged.
  - Status byte (truncation): not consumed -> IDLE, pointer=locked port-1 so that port is evaluated first next cycle.
- SYSEX:
  - Data and realtime: forward.
  - F7: forward -> IDLE.
  - Other status: not consumed -> TERM.
- TERM: emit F7 -> IDLE.
- Timeout:
  - Counter clears on each consumed byte while locked and counts while in PASS/SYSEX.
  - At TIMEOUT_CYC-1: pulse timeout; PASS -> IDLE, SYSEX -> TERM.
- Simultaneous events:
  - Output stall freezes the timeout counter (TX backpressure is not a port stall).
  - Reset mid-message abandons it; no F7 is emitted.

Decomposition:
- Package midi_pkg:
  - Status constants: ST_SYSEX=F0, ST_EOX=F7, RT_MIN=F8.
  - msg_len function.
  - State enum {IDLE, INSERT, PASS, SYSEX, TERM}.
- Sub-module rr_arbiter: PORTS-wide valid mask plus pointer in, one-hot pick out, combinational.

Test Plan:
- Port 3 sends 90 3C 7F, port 5 sends C0 05 simultaneously -> out 90 3C 7F C0 05 (pointer at 0 picks 3 first); act[3] pulses 3 times, act[5] pulses 2 times.
- Port 1 sends 90 40 7F, port 2 sends B0 07 64, then port 1 sends 40 00 -> out 90 40 7F B0 07 64 90 40 00 (inserted status).
- Port 0 holds 90 3C then idles for TIMEOUT_CYC while port 1 is valid -> timeout pulses once; next out byte is from port 1; grant 0x0001 -> 0x0002.
- Port 4 sends F0 7E 01 90 3C 7F -> out F0 7E 01 F7 90 3C 7F.
- Port 2 sends 90 3C F8 7F -> out 90 3C F8 7F; grant stays 0x0004 throughout.
- out_ready held 0 for 50 cycles mid-message, then rst pulsed -> out_valid=0, grant=0, no timeout pulse; port with data byte 3C and no running status -> dropped, nothing out.

Source files
------------

// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI constants, message length decode and the merge FSM
// state type used by midi_merge_arbiter.
package midi_pkg;

  localparam logic [7:0] ST_SYSEX = 8'hF0;
  localparam logic [7:0] ST_EOX   = 8'hF7;
  localparam logic [7:0] RT_MIN   = 8'hF8;

  typedef enum logic [2:0] {IDLE, INSERT, PASS, SYSEX, TERM} state_t;

  // Total message length including the status byte.
  // 0 means "not a fixed-length message" (data byte or SysEx start).
  function automatic logic [1:0] msg_len(input logic [7:0] b);
    logic [1:0] len;
    len = 2'd0;
    case (b[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd3;
      4'hC, 4'hD:                   len = 2'd2;
      4'hF: begin
        case (b[3:0])
          4'h0:       len = 2'd0;
          4'h1, 4'h3: len = 2'd2;
          4'h2:       len = 2'd3;
          default:    len = 2'd1;
        endcase
      end
      default: len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   valid : request mask, one bit per port
//   ptr   : last granted port; search starts at ptr+1 and wraps
//   pick  : one-hot winner, all zero when nothing is valid
module rr_arbiter #(
  parameter int PORTS = 16,
  parameter int PW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic [PORTS-1:0] valid,
  input  logic [PW-1:0]    ptr,
  output logic [PORTS-1:0] pick
);

  always_comb begin
    int   idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= PORTS; k++) begin
      idx = (int'(ptr) + k) % PORTS;
      if (!found && valid[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/midi_merge_arbiter.sv
// midi_merge_arbiter: merges PORTS MIDI byte streams onto one TX stream.
// Messages are granted atomically, running status is re-expanded per port,
// truncated SysEx is closed with F7 and stalled owners are released.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_data    : per-port head byte (port i at in_data[8i+7:8i])
//   in_ready            : per-port pop strobe (at most one bit high)
//   out_valid/out_data  : registered merged byte, held until out_ready
//   grant               : one-hot lock owner, 0 when unlocked
//   act                 : 1-cycle pulse per consumed byte, per port
//   timeout             : 1-cycle pulse when a stalled owner is released
module midi_merge_arbiter
  import midi_pkg::*;
#(
  parameter int PORTS      = 16,
  parameter int CLOCK      = 12_000_000,
  parameter int TIMEOUT_MS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PORTS-1:0]   in_valid,
  input  logic [8*PORTS-1:0] in_data,
  output logic [PORTS-1:0]   in_ready,
  output logic               out_valid,
  output logic [7:0]         out_data,
  input  logic               out_ready,
  output logic [PORTS-1:0]   grant,
  output logic [PORTS-1:0]   act,
  output logic               timeout
);

  localparam int TIMEOUT_CYC = CLOCK / 1000 * TIMEOUT_MS;
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef logic [PW-1:0] pidx_t;

  state_t                  state, state_n;
  pidx_t                   ptr, ptr_n, lock, lock_n, pick_idx;
  logic [1:0]              rem, rem_n;
  logic [7:0]              ins, ins_n, emit_byte, pb, lb;
  logic [TW-1:0]           tcnt, tcnt_n;
  logic [PORTS-1:0]        rs_vld, pick, pop;
  logic [PORTS-1:0][7:0]   rs_byte, din;
  logic                    emit, rs_set, rs_clr, to_pulse, load_ok, stall;

  assign din     = in_data;
  assign load_ok = !out_valid || out_ready;
  assign stall   = out_valid && !out_ready;
  assign pb      = din[pick_idx];
  assign lb      = din[lock];

  rr_arbiter #(.PORTS(PORTS), .PW(PW)) u_rr (
    .valid (in_valid),
    .ptr   (ptr),
    .pick  (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < PORTS; k++)
      if (pick[k]) pick_idx = pidx_t'(k);
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    lock_n    = lock;
    rem_n     = rem;
    ins_n     = ins;
    tcnt_n    = tcnt;
    pop       = '0;
    emit      = 1'b0;
    emit_byte = 8'h00;
    rs_set    = 1'b0;
    rs_clr    = 1'b0;
    to_pulse  = 1'b0;
    case (state)
      IDLE: if (|in_valid && load_ok) begin
        ptr_n = pick_idx;
        if (pb >= RT_MIN) begin
          pop[pick_idx] = 1'b1;
          emit = 1'b1; emit_byte = pb;
        end else if (pb[7]) begin
          pop[pick_idx] = 1'b1;
          emit = 1'b1; emit_byte = pb;
          lock_n = pick_idx;
          if (pb < ST_SYSEX) begin
            rs_set = 1'b1; rem_n = msg_len(pb) - 2'd1; state_n = PASS;
          end else if (pb == ST_SYSEX) begin
            rs_clr = 1'b1; state_n = SYSEX;
          end else begin
            rs_clr = 1'b1;
            if (msg_len(pb) > 2'd1) begin
              rem_n = msg_len(pb) - 2'd1; state_n = PASS;
            end
          end
        end else if (rs_vld[pick_idx]) begin
          // data under running status: leave it queued, replay status first
          lock_n = pick_idx; ins_n = rs_byte[pick_idx]; state_n = INSERT;
        end else begin
          pop[pick_idx] = 1'b1;   // orphan data byte, dropped
        end
      end
      INSERT: if (load_ok) begin
        emit = 1'b1; emit_byte = ins;
        rem_n = msg_len(ins) - 2'd1; state_n = PASS;
      end
      PASS: if (in_valid[lock] && load_ok) begin
        if (!lb[7]) begin
          pop[lock] = 1'b1; emit = 1'b1; emit_byte = lb;
          rem_n = rem - 2'd1;
          if (rem == 2'd1) state_n = IDLE;
        end else if (lb >= RT_MIN) begin
          pop[lock] = 1'b1; emit = 1'b1; emit_byte = lb;
        end else begin
          // truncated: rewind pointer so this port's new status wins next
          state_n = IDLE;
          ptr_n   = (lock == '0) ? pidx_t'(PORTS - 1) : lock - pidx_t'(1);
        end
      end
      SYSEX: if (in_valid[lock] && load_ok) begin
        if (!lb[7] || lb >= RT_MIN) begin
          pop[lock] = 1'b1; emit = 1'b1; emit_byte = lb;
        end else if (lb == ST_EOX) begin
          pop[lock] = 1'b1; emit = 1'b1; emit_byte = lb; state_n = IDLE;
        end else begin
          state_n = TERM;
        end
      end
      TERM: if (load_ok) begin
        emit = 1'b1; emit_byte = ST_EOX; state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // stall timer: TX backpressure freezes it, any consumed byte clears it
    if (state == PASS || state == SYSEX) begin
      if (|pop) tcnt_n = '0;
      else if (state_n == state && !stall) begin
        if (tcnt == T_LAST) begin
          to_pulse = 1'b1;
          tcnt_n   = '0;
          state_n  = (state == PASS) ? IDLE : TERM;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
    end else begin
      tcnt_n = '0;
    end
  end

  assign in_ready = rst ? '0 : pop;

  always_comb begin
    grant = '0;
    if (state != IDLE) grant[lock] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      lock  <= '0;
      rem   <= '0;
      ins   <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      lock  <= lock_n;
      rem   <= rem_n;
      ins   <= ins_n;
      tcnt  <= tcnt_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      act       <= '0;
      timeout   <= 1'b0;
      rs_vld    <= '0;
      rs_byte   <= '0;
    end else begin
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= emit_byte;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      act     <= pop;
      timeout <= to_pulse;
      if (rs_set) begin
        rs_vld[pick_idx]  <= 1'b1;
        rs_byte[pick_idx] <= pb;
      end
      if (rs_clr) rs_vld[pick_idx] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_midi_merge_arbiter.sv
module tb_midi_merge_arbiter;
  localparam int NP   = 16;
  localparam int TCYC = 100;   // 100_000 Hz / 1000 * 1 ms

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     in_valid;
  logic [8*NP-1:0]   in_data;
  logic [NP-1:0]     in_ready;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;
  logic [NP-1:0]     grant;
  logic [NP-1:0]     act;
  logic              timeout;

  midi_merge_arbiter #(.PORTS(NP), .CLOCK(100_000), .TIMEOUT_MS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .grant(grant), .act(act), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pa;  logic [47:0] a; int na;
    int          pb;  logic [47:0] b; int nb;
    logic [79:0] e;   int ne;
    int          acta; int actb;
    logic [15:0] gor;
  } vec_t;

  vec_t        v[8];
  logic [7:0]  q[NP][$];
  logic [7:0]  got[$];
  logic [15:0] gseq[$];
  logic [15:0] gor, glast;
  int          actcnt[NP];
  int          ab[NP];
  int          to_cnt, to_cyc, p0_cyc, cyc, nchk, npass, gb, tb0;
  logic        rdy_want;

  task automatic chk(input string name, input logic [79:0] got_v, input logic [79:0] exp_v);
    nchk++;
    if (got_v === exp_v) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, got_v, exp_v);
  endtask

  // One cycle: drive inputs at negedge, then sample what the next posedge will do.
  task automatic tick();
    @(negedge clk);
    out_ready = rdy_want;
    for (int i = 0; i < NP; i++) begin
      if (q[i].size() != 0) begin
        in_valid[i] = 1'b1; in_data[8*i +: 8] = q[i][0];
      end else begin
        in_valid[i] = 1'b0; in_data[8*i +: 8] = 8'h00;
      end
    end
    #1;
    cyc++;
    for (int i = 0; i < NP; i++)
      if (in_valid[i] && in_ready[i]) begin
        void'(q[i].pop_front());
        if (i == 0) p0_cyc = cyc;
      end
    if (out_valid && out_ready) got.push_back(out_data);
    for (int i = 0; i < NP; i++) if (act[i]) actcnt[i]++;
    if (timeout) begin to_cnt++; to_cyc = cyc; end
    gor = gor | grant;
    if (grant != 0 && grant != glast) begin gseq.push_back(grant); glast = grant; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NP; i++) q[i].delete();
    tick(); tick();
    rst = 1'b0;
    tick();
    gor = '0; glast = '0; gseq.delete();
    gb = got.size(); tb0 = to_cnt; ab = actcnt;
  endtask

  task automatic wait_quiet(input string name, input int max);
    int  quiet;
    logic ok;
    quiet = 0; ok = 1'b0;
    for (int k = 0; k < max && !ok; k++) begin
      tick();
      if (grant == 0 && !out_valid && q[0].size() + q[1].size() + q[2].size() + q[3].size()
          + q[4].size() + q[5].size() + q[6].size() + q[7].size() + q[8].size()
          + q[9].size() + q[15].size() == 0) quiet++;
      else quiet = 0;
      if (quiet >= 3) ok = 1'b1;
    end
    chk(name, 80'(ok), 80'd1);
  endtask

  function automatic logic [79:0] pack_got(input int base);
    logic [79:0] r;
    r = '0;
    for (int k = 0; k < 10; k++)
      if (base + k < got.size()) r[79-8*k -: 8] = got[base + k];
    return r;
  endfunction

  initial begin
    logic [47:0] w;
    rst = 1'b1; rdy_want = 1'b1; out_ready = 1'b1;
    in_valid = '0; in_data = '0;
    nchk = 0; npass = 0; to_cnt = 0; cyc = 0; gor = '0; glast = '0;
    for (int i = 0; i < NP; i++) actcnt[i] = 0;

    v[0] = '{3, 48'h903C7F_000000, 3, 5, 48'hC005_00000000, 2, 80'h903C7FC005_0000000000, 5, 3, 2, 16'h0028};
    v[1] = '{4, 48'hF07E01903C7F, 6, 15, 48'h0, 0, 80'hF07E01F7903C7F_000000, 7, 6, 0, 16'h0010};
    v[2] = '{2, 48'h903CF87F_0000, 4, 15, 48'h0, 0, 80'h903CF87F_000000000000, 4, 4, 0, 16'h0004};
    v[3] = '{6, 48'hF6F110_000000, 3, 7, 48'hF8_0000000000, 1, 80'hF6F8F110_000000000000, 4, 3, 1, 16'h0040};
    v[4] = '{9, 48'h3C_0000000000, 1, 15, 48'h0, 0, 80'h0, 0, 1, 0, 16'h0000};
    v[5] = '{1, 48'h90407F4000_00, 5, 2, 48'hB00764_000000, 3, 80'h90407FB00764904000_00, 9, 5, 3, 16'h0006};
    v[6] = '{2, 48'h903C91407F_00, 5, 3, 48'hC005_00000000, 2, 80'h903C91407FC005_000000, 7, 5, 2, 16'h000C};
    v[7] = '{8, 48'hF001F802F7_00, 5, 15, 48'h0, 0, 80'hF001F802F7_0000000000, 5, 5, 0, 16'h0100};

    // reset values, sampled while rst is held with a port already valid
    q[3].push_back(8'h90);
    tick();
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_out_data",  80'(out_data),  80'd0);
    chk("rst_in_ready",  80'(in_ready),  80'd0);
    chk("rst_grant",     80'(grant),     80'd0);
    chk("rst_act",       80'(act),       80'd0);
    chk("rst_timeout",   80'(timeout),   80'd0);

    for (int r = 0; r < 8; r++) begin
      do_reset();
      w = v[r].a;
      for (int k = 0; k < v[r].na; k++) q[v[r].pa].push_back(w[47-8*k -: 8]);
      w = v[r].b;
      for (int k = 0; k < v[r].nb; k++) q[v[r].pb].push_back(w[47-8*k -: 8]);
      wait_quiet($sformatf("row%0d_done", r), 300);
      chk($sformatf("row%0d_len", r),   80'(got.size() - gb), 80'(v[r].ne));
      chk($sformatf("row%0d_bytes", r), pack_got(gb), v[r].e);
      chk($sformatf("row%0d_act_a", r), 80'(actcnt[v[r].pa] - ab[v[r].pa]), 80'(v[r].acta));
      chk($sformatf("row%0d_act_b", r), 80'(actcnt[v[r].pb] - ab[v[r].pb]), 80'(v[r].actb));
      chk($sformatf("row%0d_grant", r), 80'(gor), 80'(v[r].gor));
      chk($sformatf("row%0d_no_to", r), 80'(to_cnt - tb0), 80'd0);
    end

    // stalled owner released after the timeout, then port 1 gets its turn
    do_reset();
    q[0].push_back(8'h90); q[0].push_back(8'h3C);
    for (int k = 0; k < 20 && grant != 16'h0001; k++) tick();
    chk("to_lock0", 80'(grant), 80'h1);
    q[1].push_back(8'h80); q[1].push_back(8'h3C); q[1].push_back(8'h40);
    wait_quiet("to_done", 400);
    chk("to_pulses", 80'(to_cnt - tb0), 80'd1);
    chk("to_delay_ok", 80'((to_cyc - p0_cyc >= TCYC - 1) && (to_cyc - p0_cyc <= TCYC + 2)), 80'd1);
    chk("to_bytes", pack_got(gb), 80'h903C803C40_0000000000);
    chk("to_gseq_n", 80'(gseq.size()), 80'd2);
    if (gseq.size() == 2) begin
      chk("to_gseq0", 80'(gseq[0]), 80'h1);
      chk("to_gseq1", 80'(gseq[1]), 80'h2);
    end

    // TX backpressure longer than the timeout must not release; reset abandons
    do_reset();
    q[0].push_back(8'h90); q[0].push_back(8'h3C); q[0].push_back(8'h7F);
    for (int k = 0; k < 20 && got.size() == gb; k++) tick();
    rdy_want = 1'b0;
    repeat (150) tick();
    chk("bp_no_to", 80'(to_cnt - tb0), 80'd0);
    chk("bp_hold_valid", 80'(out_valid), 80'd1);
    chk("bp_hold_data", 80'(out_data), 80'h3C);
    chk("bp_grant", 80'(grant), 80'h1);
    rst = 1'b1;
    #1;
    chk("bp_rst_valid", 80'(out_valid), 80'd0);
    chk("bp_rst_grant", 80'(grant), 80'd0);
    for (int i = 0; i < NP; i++) q[i].delete();
    tick();
    rst = 1'b0; rdy_want = 1'b1;
    gb = got.size(); ab = actcnt;
    q[0].push_back(8'h3C);
    wait_quiet("drop_done", 50);
    chk("drop_nothing_out", 80'(got.size() - gb), 80'd0);
    chk("drop_act", 80'(actcnt[0] - ab[0]), 80'd1);
    chk("bp_rst_no_to", 80'(to_cnt - tb0), 80'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
